// File: rtl/spi_sram_slave.sv
// ============================================================================
// Module   : spi_sram_slave
// Desc     : SPI mode-0 slave exposing an internal byte RAM through
//            write (0x02) and read (0x03) commands with a 24-bit address.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module spi_sram_slave #(
  parameter int MEM_AW      = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic spi_sck,
  input  logic spi_ss,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic spi_miso_oe,
  output logic busy,
  output logic wr_strobe,
  output logic rd_strobe,
  output logic cmd_err
);

  localparam int         c_MEM_DEPTH = 1 << MEM_AW;
  localparam logic [7:0] c_CMD_WRITE = 8'h02;
  localparam logic [7:0] c_CMD_READ  = 8'h03;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_ADDR   = 3'd2,
    S_WRITE  = 3'd3,
    S_READ   = 3'd4,
    S_IGNORE = 3'd5
  } state_t;

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_ss_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sck_prev;
  logic                   r_ss_prev;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [2:0]             r_bit_cnt;
  logic [1:0]             r_addr_cnt;
  logic [6:0]             r_shift;
  logic                   r_cmd_write;
  logic [MEM_AW-1:0]      r_ptr;
  logic                   r_fetch;
  logic [7:0]             r_tx;
  logic                   r_miso;
  logic                   r_oe;
  logic                   r_wr_strobe;
  logic                   r_rd_strobe;
  logic                   r_cmd_err;
  logic [7:0]             r_mem [c_MEM_DEPTH];

  logic                   w_sck_s;
  logic                   w_ss_s;
  logic                   w_mosi_s;
  logic                   w_sck_rise;
  logic                   w_sck_fall;
  logic                   w_ss_fall;
  logic                   w_byte_done;
  logic [7:0]             w_byte;
  logic                   w_cmd_err;
  logic                   w_mem_we;
  logic                   w_fetch_req;
  logic                   w_fetch_go;

  // Select idles high after reset so a held-low select is seen as a fresh falling edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sck_sync  <= '0;
      r_ss_sync   <= '1;
      r_mosi_sync <= '0;
      r_sck_prev  <= 1'b0;
      r_ss_prev   <= 1'b1;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], spi_ss};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      r_sck_prev  <= w_sck_s;
      r_ss_prev   <= w_ss_s;
    end
  end

  assign w_sck_s     = r_sck_sync[SYNC_STAGES-1];
  assign w_ss_s      = r_ss_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign w_sck_rise  = w_sck_s & ~r_sck_prev & ~w_ss_s;
  assign w_sck_fall  = ~w_sck_s & r_sck_prev & ~w_ss_s;
  assign w_ss_fall   = ~w_ss_s & r_ss_prev;
  assign w_byte      = {r_shift, w_mosi_s};
  assign w_byte_done = w_sck_rise && (r_bit_cnt == 3'd7);
  assign w_fetch_go  = r_fetch && (r_state == S_READ) && !w_ss_s;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_cmd_err    = 1'b0;
    w_mem_we     = 1'b0;
    w_fetch_req  = 1'b0;
    if (w_ss_s) begin
      w_state_next = S_IDLE;
    end else if (w_ss_fall) begin
      w_state_next = S_CMD;
    end else if (w_byte_done) begin
      case (r_state)
        S_CMD: begin
          if (w_byte == c_CMD_WRITE || w_byte == c_CMD_READ) begin
            w_state_next = S_ADDR;
          end else begin
            w_state_next = S_IGNORE;
            w_cmd_err    = 1'b1;
          end
        end
        S_ADDR: begin
          if (r_addr_cnt == 2'd2) begin
            w_state_next = r_cmd_write ? S_WRITE : S_READ;
            w_fetch_req  = !r_cmd_write;
          end
        end
        S_WRITE: w_mem_we    = 1'b1;
        S_READ:  w_fetch_req = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_bit_cnt   <= 3'd0;
      r_addr_cnt  <= 2'd0;
      r_shift     <= 7'd0;
      r_cmd_write <= 1'b0;
      r_ptr       <= '0;
      r_fetch     <= 1'b0;
      r_tx        <= 8'd0;
      r_miso      <= 1'b0;
      r_oe        <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_rd_strobe <= 1'b0;
      r_cmd_err   <= 1'b0;
    end else begin
      if (w_ss_s || w_ss_fall) r_bit_cnt <= 3'd0;
      else if (w_sck_rise)     r_bit_cnt <= r_bit_cnt + 3'd1;

      if (w_sck_rise) r_shift <= w_byte[6:0];

      if (w_ss_fall)                                r_addr_cnt <= 2'd0;
      else if (r_state == S_ADDR && w_byte_done)    r_addr_cnt <= r_addr_cnt + 2'd1;

      if (r_state == S_CMD && w_byte_done) r_cmd_write <= (w_byte == c_CMD_WRITE);

      // Shifting all 24 address bits through the pointer keeps only the low MEM_AW bits.
      if (r_state == S_ADDR && w_sck_rise) r_ptr <= {r_ptr[MEM_AW-2:0], w_mosi_s};
      else if (w_mem_we || w_fetch_go)     r_ptr <= r_ptr + 1'b1;

      if (w_ss_s)           r_fetch <= 1'b0;
      else if (w_fetch_req) r_fetch <= 1'b1;
      else if (w_fetch_go)  r_fetch <= 1'b0;

      if (w_fetch_go)                           r_tx <= r_mem[r_ptr];
      else if (r_state == S_READ && w_sck_fall) r_tx <= {r_tx[6:0], 1'b0};

      if (w_state_next != S_READ) begin
        r_miso <= 1'b0;
        r_oe   <= 1'b0;
      end else if (r_state == S_READ && w_sck_fall) begin
        r_miso <= r_tx[7];
        r_oe   <= 1'b1;
      end

      r_wr_strobe <= w_mem_we;
      r_rd_strobe <= w_fetch_go;
      r_cmd_err   <= w_cmd_err;
    end
  end

  // Storage is deliberately left out of reset so contents survive it.
  always_ff @(posedge clock) begin
    if (w_mem_we) r_mem[r_ptr] <= w_byte;
  end

  assign spi_miso    = r_miso;
  assign spi_miso_oe = r_oe;
  assign busy        = ~w_ss_s;
  assign wr_strobe   = r_wr_strobe;
  assign rd_strobe   = r_rd_strobe;
  assign cmd_err     = r_cmd_err;

endmodule

`default_nettype wire

// File: tb/tb_spi_sram_slave.sv
// ============================================================================
// Module   : tb_spi_sram_slave
// Desc     : Directed self-checking bench for spi_sram_slave (SPI mode 0 master model).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_spi_sram_slave;

  localparam int HALF = 60;

  logic clock    = 1'b0;
  logic reset    = 1'b1;
  logic spi_sck  = 1'b0;
  logic spi_ss   = 1'b1;
  logic spi_mosi = 1'b0;
  logic spi_miso;
  logic spi_miso_oe;
  logic busy;
  logic wr_strobe;
  logic rd_strobe;
  logic cmd_err;

  int checks   = 0;
  int failures = 0;
  int wr_cnt   = 0;
  int rd_cnt   = 0;
  int err_cnt  = 0;
  int miso_bad = 0;

  spi_sram_slave #(.MEM_AW(10), .SYNC_STAGES(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .spi_sck    (spi_sck),
    .spi_ss     (spi_ss),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .spi_miso_oe(spi_miso_oe),
    .busy       (busy),
    .wr_strobe  (wr_strobe),
    .rd_strobe  (rd_strobe),
    .cmd_err    (cmd_err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (wr_strobe === 1'b1) wr_cnt++;
    if (rd_strobe === 1'b1) rd_cnt++;
    if (cmd_err === 1'b1)   err_cnt++;
  end

  always @(negedge clock) begin
    if (spi_miso === 1'b1 && spi_miso_oe !== 1'b1) miso_bad++;
  end

  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx,
                      output bit oe_hi, output bit oe_lo);
    rx = '0; oe_hi = 0; oe_lo = 0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi_mosi = tx[i];
      #(HALF);
      rx = {rx[6:0], spi_miso};
      if (spi_miso_oe === 1'b1) oe_hi = 1; else oe_lo = 1;
      spi_sck = 1'b1;
      #(HALF);
      spi_sck = 1'b0;
    end
  endtask

  task automatic ss_low();
    spi_ss = 1'b0;
    #(HALF);
  endtask

  task automatic ss_high();
    #(HALF);
    spi_ss = 1'b1;
    #(2*HALF);
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] a, output bit oe_hi);
    logic [7:0] rx;
    bit h, l;
    oe_hi = 0;
    xfer(cmd, 8, rx, h, l);        oe_hi |= h;
    xfer(a[23:16], 8, rx, h, l);   oe_hi |= h;
    xfer(a[15:8], 8, rx, h, l);    oe_hi |= h;
    xfer(a[7:0], 8, rx, h, l);     oe_hi |= h;
  endtask

  task automatic spi_write(input logic [23:0] a, input logic [15:0] d, input int n);
    logic [7:0] rx;
    bit h, l;
    ss_low();
    send_hdr(8'h02, a, h);
    xfer(d[15:8], 8, rx, h, l);
    if (n == 2) xfer(d[7:0], 8, rx, h, l);
    ss_high();
  endtask

  task automatic spi_read(input logic [23:0] a, input int n, output logic [15:0] d,
                          output bit hdr_oe, output bit data_oe_lo);
    logic [7:0] rx;
    bit h, l;
    d = '0; data_oe_lo = 0;
    ss_low();
    send_hdr(8'h03, a, hdr_oe);
    for (int k = 0; k < n; k++) begin
      xfer(8'h00, 8, rx, h, l);
      d = {d[7:0], rx};
      data_oe_lo |= l;
    end
    ss_high();
  endtask

  task automatic test_reset();
    #30;
    checks += 6;
    if (spi_miso !== 1'b0)    begin failures++; $display("FAIL reset_miso got=%b exp=0", spi_miso); end
    if (spi_miso_oe !== 1'b0) begin failures++; $display("FAIL reset_oe got=%b exp=0", spi_miso_oe); end
    if (busy !== 1'b0)        begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (wr_strobe !== 1'b0)   begin failures++; $display("FAIL reset_wr got=%b exp=0", wr_strobe); end
    if (rd_strobe !== 1'b0)   begin failures++; $display("FAIL reset_rd got=%b exp=0", rd_strobe); end
    if (cmd_err !== 1'b0)     begin failures++; $display("FAIL reset_err got=%b exp=0", cmd_err); end
    reset = 1'b0;
    #40;
  endtask

  task automatic test_write();
    logic [7:0] rx;
    bit h, l;
    int wr0, err0;
    wr0 = wr_cnt; err0 = err_cnt;
    ss_low();
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL write_busy_hi got=%b exp=1", busy); end
    send_hdr(8'h02, 24'h000010, h);
    xfer(8'hA5, 8, rx, h, l);
    xfer(8'h3C, 8, rx, h, l);
    ss_high();
    checks += 3;
    if (wr_cnt - wr0 != 2)   begin failures++; $display("FAIL write_strobes got=%0d exp=2", wr_cnt - wr0); end
    if (err_cnt - err0 != 0) begin failures++; $display("FAIL write_cmd_err got=%0d exp=0", err_cnt - err0); end
    if (busy !== 1'b0)       begin failures++; $display("FAIL write_busy_lo got=%b exp=0", busy); end
  endtask

  task automatic test_read();
    logic [15:0] d;
    bit hdr_oe, data_lo;
    int rd0;
    rd0 = rd_cnt;
    spi_read(24'h000010, 2, d, hdr_oe, data_lo);
    checks += 5;
    if (d[15:8] !== 8'hA5) begin failures++; $display("FAIL read_b0 got=%h exp=a5", d[15:8]); end
    if (d[7:0] !== 8'h3C)  begin failures++; $display("FAIL read_b1 got=%h exp=3c", d[7:0]); end
    if (hdr_oe)            begin failures++; $display("FAIL read_hdr_oe got=1 exp=0"); end
    if (data_lo)           begin failures++; $display("FAIL read_data_oe got=0 exp=1"); end
    if (rd_cnt - rd0 < 2)  begin failures++; $display("FAIL read_strobes got=%0d exp>=2", rd_cnt - rd0); end
  endtask

  task automatic test_wrap();
    logic [15:0] d;
    bit hdr_oe, data_lo;
    int wr0;
    wr0 = wr_cnt;
    spi_write(24'h0003FF, 16'h1122, 2);
    checks++;
    if (wr_cnt - wr0 != 2) begin failures++; $display("FAIL wrap_strobes got=%0d exp=2", wr_cnt - wr0); end
    spi_read(24'h0003FF, 2, d, hdr_oe, data_lo);
    checks += 2;
    if (d[15:8] !== 8'h11) begin failures++; $display("FAIL wrap_rd_3ff got=%h exp=11", d[15:8]); end
    if (d[7:0] !== 8'h22)  begin failures++; $display("FAIL wrap_rd_wrap got=%h exp=22", d[7:0]); end
    spi_read(24'h000000, 1, d, hdr_oe, data_lo);
    checks++;
    if (d[7:0] !== 8'h22)  begin failures++; $display("FAIL wrap_rd_000 got=%h exp=22", d[7:0]); end
  endtask

  task automatic test_bad_cmd();
    logic [7:0] rx;
    logic [15:0] d;
    bit h, l, oe_any, hdr_oe, data_lo;
    int err0, wr0, bad0;
    err0 = err_cnt; wr0 = wr_cnt; bad0 = miso_bad;
    ss_low();
    send_hdr(8'h05, 24'h000010, oe_any);
    xfer(8'hFF, 8, rx, h, l);
    oe_any |= h;
    ss_high();
    checks += 4;
    if (err_cnt - err0 != 1)   begin failures++; $display("FAIL bad_cmd_err got=%0d exp=1", err_cnt - err0); end
    if (oe_any)                begin failures++; $display("FAIL bad_cmd_oe got=1 exp=0"); end
    if (miso_bad - bad0 != 0)  begin failures++; $display("FAIL bad_cmd_miso got=%0d exp=0", miso_bad - bad0); end
    if (wr_cnt - wr0 != 0)     begin failures++; $display("FAIL bad_cmd_wr got=%0d exp=0", wr_cnt - wr0); end
    spi_read(24'h000010, 2, d, hdr_oe, data_lo);
    checks++;
    if (d !== 16'hA53C) begin failures++; $display("FAIL bad_cmd_mem got=%h exp=a53c", d); end
  endtask

  task automatic test_abort();
    logic [7:0] rx;
    logic [15:0] d;
    bit h, l, hdr_oe, data_lo;
    int wr0, bad0;
    spi_write(24'h000020, 16'h5A00, 1);
    wr0 = wr_cnt; bad0 = miso_bad;
    ss_low();
    send_hdr(8'h02, 24'h000020, h);
    xfer(8'hFF, 5, rx, h, l);
    ss_high();
    checks += 4;
    if (busy !== 1'b0)        begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    if (spi_miso_oe !== 1'b0) begin failures++; $display("FAIL abort_oe got=%b exp=0", spi_miso_oe); end
    if (wr_cnt - wr0 != 0)    begin failures++; $display("FAIL abort_wr got=%0d exp=0", wr_cnt - wr0); end
    if (miso_bad - bad0 != 0) begin failures++; $display("FAIL abort_miso got=%0d exp=0", miso_bad - bad0); end
    spi_read(24'h000020, 1, d, hdr_oe, data_lo);
    checks++;
    if (d[7:0] !== 8'h5A) begin failures++; $display("FAIL abort_mem got=%h exp=5a", d[7:0]); end
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] rx;
    logic [15:0] d;
    bit h, l, hdr_oe, data_lo;
    ss_low();
    send_hdr(8'h03, 24'h000010, h);
    xfer(8'h00, 8, rx, h, l);
    checks += 2;
    if (rx !== 8'hA5)         begin failures++; $display("FAIL rst_read_b0 got=%h exp=a5", rx); end
    xfer(8'h00, 3, rx, h, l);
    if (spi_miso_oe !== 1'b1) begin failures++; $display("FAIL rst_read_oe got=%b exp=1", spi_miso_oe); end
    #20;
    reset = 1'b1;
    #1;
    checks += 6;
    if (spi_miso !== 1'b0)    begin failures++; $display("FAIL rst_mid_miso got=%b exp=0", spi_miso); end
    if (spi_miso_oe !== 1'b0) begin failures++; $display("FAIL rst_mid_oe got=%b exp=0", spi_miso_oe); end
    if (busy !== 1'b0)        begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    if (wr_strobe !== 1'b0)   begin failures++; $display("FAIL rst_mid_wr got=%b exp=0", wr_strobe); end
    if (rd_strobe !== 1'b0)   begin failures++; $display("FAIL rst_mid_rd got=%b exp=0", rd_strobe); end
    if (cmd_err !== 1'b0)     begin failures++; $display("FAIL rst_mid_err got=%b exp=0", cmd_err); end
    spi_ss = 1'b1;
    #50;
    reset = 1'b0;
    #50;
    spi_read(24'h000011, 1, d, hdr_oe, data_lo);
    checks++;
    if (d[7:0] !== 8'h3C) begin failures++; $display("FAIL rst_readback got=%h exp=3c", d[7:0]); end
  endtask

  initial begin
    #2;
    test_reset();
    test_write();
    test_read();
    test_wrap();
    test_bad_cmd();
    test_abort();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/spi_sram_slave.md
SPI_SRAM_SLAVE -- requirements
Module: spi_sram_slave

Interface
REQ-001 SHALL have parameter MEM_AW, default 10, meaning log2 of internal byte-array depth (1 KiB).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer flops on spi_sck, spi_ss and spi_mosi.
REQ-003 SHALL have port clock  input  1  system clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port spi_sck  input  1  serial clock from master; idles high or low while spi_ss is high.
REQ-006 SHALL have port spi_ss  input  1  slave select, active-low.
REQ-007 SHALL have port spi_mosi  input  1  serial data from master, MSB first.
REQ-008 SHALL have port spi_miso  output  1  serial data to master, MSB first.
REQ-009 SHALL have port spi_miso_oe  output  1  high only while read data is driven.
REQ-010 SHALL have port busy  output  1  synchronized spi_ss is low.
REQ-011 SHALL have port wr_strobe  output  1  one-cycle pulse per byte committed to memory.
REQ-012 SHALL have port rd_strobe  output  1  one-cycle pulse per byte fetched for transmission.
REQ-013 SHALL have port cmd_err  output  1  one-cycle pulse when an unsupported command byte completes.

Function
REQ-014 SHALL require SCK high and low phases of at least 4 clock periods each; behaviour outside this is undefined.
REQ-015 SHALL implement SPI mode 0: sample spi_mosi on synchronized SCK rising edge; update spi_miso on synchronized SCK falling edge.
REQ-016 SHALL ignore all SCK edges while synchronized spi_ss is high.
REQ-017 SHALL, on synchronized spi_ss falling edge, clear the 3-bit bit counter and enter state CMD.
REQ-018 SHALL implement states IDLE, CMD, ADDR, WRITE, READ, IGNORE.
REQ-019 SHALL, in CMD after 8 bits: 0x02 -> ADDR (write), 0x03 -> ADDR (read), any other value -> IGNORE with cmd_err pulse.
REQ-020 SHALL receive 3 address bytes (24 bits) in ADDR; use address[MEM_AW-1:0], discard upper bits.
REQ-021 SHALL, after the 24th address bit, go to WRITE or READ per latched command.
REQ-022 SHALL, in WRITE, write each completed 8-bit byte to memory at the current pointer within 2 clocks of the 8th rising edge, pulse wr_strobe, then increment pointer.
REQ-023 SHALL, in READ, fetch memory[pointer] with rd_strobe pulse, present bit 7 on spi_miso after the SCK falling edge following the last address bit, shift one bit per falling edge, then fetch next byte (pointer+1) before the next byte's first falling edge.
REQ-024 SHALL wrap the pointer from 2^MEM_AW-1 to 0 in both WRITE and READ.
REQ-025 SHALL hold spi_miso 0 and spi_miso_oe 0 in IDLE, CMD, ADDR, WRITE, IGNORE.
REQ-026 SHALL remain in IGNORE, drop all bits, until spi_ss rises.
REQ-027 SHALL, on spi_ss rising in any state, return to IDLE within SYNC_STAGES+1 clocks and discard any partial byte (no memory write).
REQ-028 SHALL treat an spi_ss rise before address completion as an aborted transaction with no memory access.

Reset
REQ-029 SHALL, on reset, set state IDLE, bit counter 0, pointer 0, synchronizers to spi_ss=1, and spi_miso, spi_miso_oe, busy, wr_strobe, rd_strobe, cmd_err all 0.
REQ-030 SHALL NOT clear memory contents on reset; reset mid-transaction aborts it, and any partial byte is lost.

Verification
REQ-031 Write 0x02, addr 0x000010, data 0xA5 0x3C -> mem[0x10]=0xA5, mem[0x11]=0x3C, two wr_strobe pulses.
REQ-032 Read 0x03, addr 0x000010, 2 bytes -> MISO yields 0xA5 then 0x3C, spi_miso_oe high only in data phase.
REQ-033 Write at addr 0x0003FF bytes 0x11 0x22 -> mem[0x3FF]=0x11, mem[0x000]=0x22 (wrap); readback matches.
REQ-034 Command 0x05 followed by 4 bytes -> one cmd_err pulse, MISO 0, memory unchanged.
REQ-035 Write 0x02 addr 0x20, then 5 data bits and spi_ss rise -> mem[0x20] unchanged, state IDLE, busy 0.
REQ-036 Reset asserted mid-READ -> all outputs 0 immediately; next read of a previously written location returns the stored value.
